// File: rtl/image_op_scheduler.sv
// image_op_scheduler: runs the mirror, gray and filter engines in that order.
// Only the engines selected by op_mask are run. The scheduler launches each one
// and gives it sole use of the shared 64x64 image-memory address/write port
// until the engine reports done.
// Optional macro TIMEOUT_EN: limits the number of RUN cycles per engine to
// TIMEOUT_CYCLES and flags the op in err. Without it, err is tied low.
module image_op_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [2:0]  op_mask,
  output logic [2:0]  eng_start,
  input  logic [2:0]  eng_done,
  input  logic [17:0] eng_row,
  input  logic [17:0] eng_col,
  input  logic [2:0]  eng_we,
  input  logic [71:0] eng_pix,
  output logic [5:0]  mem_row,
  output logic [5:0]  mem_col,
  output logic        mem_we,
  output logic [23:0] mem_pix,
  output logic [1:0]  cur_op,
  output logic        busy,
  output logic [2:0]  op_done,
  output logic        all_done,
  output logic [2:0]  err
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_LAUNCH,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t     state;
  logic [1:0] idx;
  logic [2:0] mask_q;
  logic       run_first;
  logic [2:0] eng_start_q;
  logic [2:0] op_done_q;
  logic       all_done_q;
  logic       busy_q;
  logic       done_hit;
  logic       timeout_hit;
  logic       advance;
  logic       accept_start;

  function automatic logic bit_at(input logic [2:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return v[0];
      2'd1:    return v[1];
      2'd2:    return v[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    case (i)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  assign accept_start = start && (state == ST_IDLE || state == ST_DONE);
  // The done level is not trusted in the first RUN cycle, because the engine may still show the previous run's done.
  assign done_hit     = (state == ST_RUN) && !run_first && bit_at(eng_done, idx);
  assign advance      = done_hit || timeout_hit;

`ifdef TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] run_cnt;
  logic [2:0]       err_q;

  // The counter holds the RUN cycles already elapsed. The limit is reached on the TIMEOUT_CYCLES-th RUN cycle.
  assign timeout_hit = (state == ST_RUN) && !done_hit &&
                       (run_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Per-engine RUN cycle counter and sticky timeout flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
      err_q   <= '0;
    end else begin
      if (abort || accept_start)
        err_q <= '0;
      else if (timeout_hit)
        err_q <= err_q | onehot(idx);
      if (state == ST_LAUNCH)
        run_cnt <= '0;
      else if (state == ST_RUN)
        run_cnt <= run_cnt + CNT_W'(1);
    end
  end

  assign err = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err         = '0;
`endif

  // Sequencer: select -> launch -> run for each enabled engine, with abort taking priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      mask_q      <= '0;
      run_first   <= 1'b0;
      eng_start_q <= '0;
      op_done_q   <= '0;
      all_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      eng_start_q <= '0;
      if (abort) begin
        state      <= ST_IDLE;
        idx        <= '0;
        op_done_q  <= '0;
        all_done_q <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              mask_q     <= op_mask;
              op_done_q  <= '0;
              all_done_q <= 1'b0;
              idx        <= '0;
              busy_q     <= 1'b1;
              state      <= ST_SELECT;
            end
          end
          ST_SELECT: begin
            if (bit_at(mask_q, idx)) begin
              eng_start_q <= onehot(idx);
              state       <= ST_LAUNCH;
            end else if (idx == 2'd2) begin
              busy_q     <= 1'b0;
              all_done_q <= 1'b1;
              state      <= ST_DONE;
            end else begin
              idx <= idx + 2'd1;
            end
          end
          ST_LAUNCH: begin
            run_first <= 1'b1;
            state     <= ST_RUN;
          end
          ST_RUN: begin
            run_first <= 1'b0;
            if (advance) begin
              if (done_hit)
                op_done_q <= op_done_q | onehot(idx);
              if (idx == 2'd2) begin
                busy_q     <= 1'b0;
                all_done_q <= 1'b1;
                state      <= ST_DONE;
              end else begin
                idx   <= idx + 2'd1;
                state <= ST_SELECT;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Grant mux: only the launched/running engine reaches memory; abort kills the write at once
  always_comb begin
    mem_row = '0;
    mem_col = '0;
    mem_pix = '0;
    mem_we  = 1'b0;
    cur_op  = 2'd3;
    if (state == ST_LAUNCH || state == ST_RUN) begin
      cur_op = idx;
      case (idx)
        2'd0: begin
          mem_row = eng_row[5:0];
          mem_col = eng_col[5:0];
          mem_pix = eng_pix[23:0];
          mem_we  = eng_we[0];
        end
        2'd1: begin
          mem_row = eng_row[11:6];
          mem_col = eng_col[11:6];
          mem_pix = eng_pix[47:24];
          mem_we  = eng_we[1];
        end
        2'd2: begin
          mem_row = eng_row[17:12];
          mem_col = eng_col[17:12];
          mem_pix = eng_pix[71:48];
          mem_we  = eng_we[2];
        end
        default: ;
      endcase
      if (abort)
        mem_we = 1'b0;
    end
  end

  assign eng_start = eng_start_q & {3{~abort}};
  assign op_done   = op_done_q;
  assign all_done  = all_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_image_op_scheduler.sv
// Directed bench for image_op_scheduler. Behavioural engine models raise done a
// programmable number of cycles after their start pulse. A delay of 0 means the
// engine never finishes.
module tb_image_op_scheduler;

`ifdef TIMEOUT_EN
  localparam int unsigned TO_CYC = 50;
`else
  localparam int unsigned TO_CYC = 65535;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  op_mask = '0;
  logic [2:0]  eng_start;
  logic [2:0]  eng_done;
  logic [17:0] eng_row;
  logic [17:0] eng_col;
  logic [2:0]  eng_we;
  logic [71:0] eng_pix;
  logic [5:0]  mem_row;
  logic [5:0]  mem_col;
  logic        mem_we;
  logic [23:0] mem_pix;
  logic [1:0]  cur_op;
  logic        busy;
  logic [2:0]  op_done;
  logic        all_done;
  logic [2:0]  err;

  logic [2:0]  done_a = '0;
  logic        we_a[3];
  logic [5:0]  row_a[3];
  logic [5:0]  col_a[3];
  logic [23:0] pix_a[3];

  assign eng_done = done_a;
  assign eng_we   = {we_a[2], we_a[1], we_a[0]};
  assign eng_row  = {row_a[2], row_a[1], row_a[0]};
  assign eng_col  = {col_a[2], col_a[1], col_a[0]};
  assign eng_pix  = {pix_a[2], pix_a[1], pix_a[0]};

  image_op_scheduler #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op_mask(op_mask),
    .eng_start(eng_start), .eng_done(eng_done), .eng_row(eng_row),
    .eng_col(eng_col), .eng_we(eng_we), .eng_pix(eng_pix),
    .mem_row(mem_row), .mem_col(mem_col), .mem_we(mem_we), .mem_pix(mem_pix),
    .cur_op(cur_op), .busy(busy), .op_done(op_done), .all_done(all_done),
    .err(err)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;
  int cyc;
  int dly[3];
  int cnt[3] = '{0, 0, 0};
  logic [2:0] starts[$];
  int t_st[3];
  int t_od0;
  int t_err0;
  int viol;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample 1 time unit after the edge, then update the engine models and monitors.
  task automatic tick();
    int k;
    @(posedge clk);
    #1;
    cyc++;
    if (eng_start != '0) starts.push_back(eng_start);
    for (int i = 0; i < 3; i++) begin
      if (eng_start[i]) begin
        t_st[i] = cyc;
        done_a[i] = 1'b0;
        cnt[i] = dly[i];
      end else if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) done_a[i] = 1'b1;
      end
    end
    if (op_done[0] && t_od0 < 0) t_od0 = cyc;
    if (err[0] && t_err0 < 0) t_err0 = cyc;
    if (mem_we) begin
      k = int'(cur_op);
      if (k > 2) viol++;
      else if (!we_a[k] || mem_pix != pix_a[k] || mem_row != row_a[k] || mem_col != col_a[k])
        viol++;
    end
  endtask

  task automatic clear_rec();
    starts.delete();
    for (int i = 0; i < 3; i++) t_st[i] = -1;
    t_od0 = -1;
    t_err0 = -1;
    viol = 0;
    cyc = 0;
  endtask

  task automatic do_start(input logic [2:0] m);
    clear_rec();
    op_mask = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_all(input int maxc);
    for (int n = 0; n < maxc && !all_done; n++) tick();
  endtask

  task automatic wait_grant(input logic [1:0] op, input int maxc);
    for (int n = 0; n < maxc && cur_op != op; n++) tick();
  endtask

  function automatic logic [2:0] start_at(input int i);
    if (starts.size() > i) return starts[i];
    return 3'b000;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      we_a[i] = 1'b0; row_a[i] = '0; col_a[i] = '0; pix_a[i] = '0; dly[i] = 0;
    end
    clear_rec();
    #1 rst_n = 1'b0;
    #2;
    check("rst_eng_start", eng_start, 3'b000);
    check("rst_op_done", op_done, 3'b000);
    check("rst_err", err, 3'b000);
    check("rst_all_done", all_done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_pix", mem_pix, 24'h0);
    check("rst_cur_op", cur_op, 2'd3);
    #9 rst_n = 1'b1;

    // All three engines with writes enabled and distinct pixels
    dly[0] = 10; dly[1] = 20; dly[2] = 30;
    for (int i = 0; i < 3; i++) begin
      we_a[i] = 1'b1; row_a[i] = 6'(i + 1); col_a[i] = 6'(i + 10);
    end
    pix_a[0] = 24'h111111; pix_a[1] = 24'h222222; pix_a[2] = 24'h333333;
    do_start(3'b111);
    check("m111_busy", busy, 1'b1);
    wait_all(300);
    check("m111_all_done", all_done, 1'b1);
    check("m111_op_done", op_done, 3'b111);
    check("m111_busy_end", busy, 1'b0);
    check("m111_cur_op_end", cur_op, 2'd3);
    check("m111_n_starts", starts.size(), 3);
    check("m111_start0", start_at(0), 3'b001);
    check("m111_start1", start_at(1), 3'b010);
    check("m111_start2", start_at(2), 3'b100);
    check("m111_gap", t_st[1] - t_od0, 1);
    check("m111_we_follow", viol, 0);

    // Skip gray: one extra SELECT cycle between mirror done and filter start
    dly[0] = 4; dly[1] = 4; dly[2] = 4;
    do_start(3'b101);
    wait_all(100);
    check("m101_all_done", all_done, 1'b1);
    check("m101_op_done", op_done, 3'b101);
    check("m101_err", err, 3'b000);
    check("m101_no_gray", t_st[1], -1);
    check("m101_n_starts", starts.size(), 2);
    check("m101_gap", t_st[2] - t_od0, 2);

    // Empty mask: busy for three cycles, then done
    do_start(3'b000);
    check("m000_busy1", busy, 1'b1);
    check("m000_clr_done", all_done, 1'b0);
    tick();
    check("m000_busy2", busy, 1'b1);
    tick();
    check("m000_busy3", busy, 1'b1);
    check("m000_not_yet", all_done, 1'b0);
    tick();
    check("m000_all_done", all_done, 1'b1);
    check("m000_busy_end", busy, 1'b0);
    check("m000_no_start", starts.size(), 0);

    // Gray running while mirror tries to write
    dly[0] = 10; dly[1] = 40; dly[2] = 10;
    pix_a[0] = 24'hFFFFFF; row_a[0] = 6'd1; col_a[0] = 6'd1;
    pix_a[1] = 24'h004000; row_a[1] = 6'd5; col_a[1] = 6'd7;
    do_start(3'b010);
    wait_grant(2'd1, 20);
    check("gray_grant", cur_op, 2'd1);
    tick();
    check("gray_we", mem_we, 1'b1);
    check("gray_pix", mem_pix, 24'h004000);
    check("gray_row", mem_row, 6'd5);
    check("gray_col", mem_col, 6'd7);
    we_a[1] = 1'b0;
    #1;
    check("gray_no_leak", mem_we, 1'b0);
    we_a[1] = 1'b1;
    wait_all(100);
    check("gray_op_done", op_done, 3'b010);
    check("gray_only_start", start_at(0), 3'b010);
    check("gray_we_follow", viol, 0);

    // Mirror run: start ignored, then abort
    dly[0] = 1000; dly[1] = 5; dly[2] = 5;
    do_start(3'b111);
    repeat (5) tick();
    check("ab_grant", cur_op, 2'd0);
    check("ab_we_before", mem_we, 1'b1);
    op_mask = 3'b000;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ab_start_ignored_busy", busy, 1'b1);
    check("ab_start_ignored_op", cur_op, 2'd0);
    abort = 1'b1;
    #1;
    check("ab_we_forced", mem_we, 1'b0);
    tick();
    abort = 1'b0;
    check("ab_idle_busy", busy, 1'b0);
    check("ab_idle_op", cur_op, 2'd3);
    check("ab_op_done", op_done, 3'b000);
    check("ab_all_done", all_done, 1'b0);

    // abort and start together: abort wins
    clear_rec();
    op_mask = 3'b111;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();
    check("abst_busy", busy, 1'b0);
    check("abst_no_start", starts.size(), 0);

    // Asynchronous reset during the gray run, with mirror already done
    dly[0] = 3; dly[1] = 200; dly[2] = 5;
    do_start(3'b111);
    wait_grant(2'd1, 50);
    tick();
    check("rr_pre_op_done", op_done, 3'b001);
    #2 rst_n = 1'b0;
    #1;
    check("rr_op_done", op_done, 3'b000);
    check("rr_busy", busy, 1'b0);
    check("rr_cur_op", cur_op, 2'd3);
    check("rr_mem_we", mem_we, 1'b0);
    check("rr_mem_pix", mem_pix, 24'h0);
    check("rr_eng_start", eng_start, 3'b000);
    #2 rst_n = 1'b1;
    tick();

`ifdef TIMEOUT_EN
    // Mirror never finishes; it times out after 50 RUN cycles
    dly[0] = 0; dly[1] = 5; dly[2] = 5;
    do_start(3'b111);
    wait_all(400);
    check("to_all_done", all_done, 1'b1);
    check("to_err", err, 3'b001);
    check("to_op_done", op_done, 3'b110);
    check("to_latency", t_err0 - t_st[0], 51);
    check("to_next_start", (t_st[1] - t_err0 >= 1) && (t_st[1] - t_err0 <= 2), 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
